// File: rtl/des_key_sched_dec_if.sv
// Handshake and data bundle between the DES decrypt key scheduler and its consumer.
// Bit index i of every bus carries FIPS 46-3 bit i.
interface des_key_sched_dec_if;
  logic [64:1] key_in;
  logic        key_load;
  logic        busy;
  logic [48:1] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [5:1]  round_num;
  logic        last;

  modport master (
    output key_in, key_load, subkey_ready,
    input  busy, subkey, subkey_valid, round_num, last
  );

  modport slave (
    input  key_in, key_load, subkey_ready,
    output busy, subkey, subkey_valid, round_num, last
  );
endinterface

// File: rtl/des_key_sched_dec.sv
// Sequential DES decryption key scheduler: emits K16 down to K1, one subkey per handshake,
// by right-rotating the PC-1 halves between rounds.
module des_key_sched_dec (
  input  logic                 clk,
  input  logic                 rst,
  des_key_sched_dec_if.slave   bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam int unsigned Pc1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned Pc2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  state_e      state_q, state_d;
  logic [28:1] c_q, c_d;
  logic [28:1] dh_q, dh_d;
  logic [5:1]  rnd_q, rnd_d;

  logic [56:1] pc1_out;
  logic [56:1] cd;
  logic [48:1] pc2_out;
  logic        single_shift;

  // Index-wise right rotate: new[j] = old[j-1], new[1] = old[28].
  function automatic logic [28:1] ror1(input logic [28:1] x);
    return {x[27:1], x[28]};
  endfunction

  always_comb begin
    pc1_out = '0;
    for (int i = 1; i <= 56; i++) begin
      pc1_out[i] = bus.key_in[Pc1[i-1]];
    end
  end

  assign cd = {dh_q, c_q};

  always_comb begin
    pc2_out = '0;
    for (int i = 1; i <= 48; i++) begin
      pc2_out[i] = cd[Pc2[i-1]];
    end
  end

  // Shift of encryption round rnd; undone here going from round rnd to rnd-1.
  assign single_shift = (rnd_q == 5'd1) || (rnd_q == 5'd2) || (rnd_q == 5'd9) ||
                        (rnd_q == 5'd16);

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    dh_d    = dh_q;
    rnd_d   = rnd_q;
    unique case (state_q)
      StIdle: begin
        // C16/D16 equal C0/D0 since the encryption shifts total 28.
        if (bus.key_load) begin
          c_d     = pc1_out[28:1];
          dh_d    = pc1_out[56:29];
          rnd_d   = 5'd16;
          state_d = StRun;
        end
      end
      StRun: begin
        if (bus.subkey_ready) begin
          if (rnd_q == 5'd1) begin
            state_d = StIdle;
          end else begin
            c_d   = single_shift ? ror1(c_q) : ror1(ror1(c_q));
            dh_d  = single_shift ? ror1(dh_q) : ror1(ror1(dh_q));
            rnd_d = rnd_q - 5'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      c_q     <= '0;
      dh_q    <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      dh_q    <= dh_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    bus.busy         = (state_q == StRun);
    bus.subkey_valid = (state_q == StRun);
    bus.subkey       = pc2_out;
    bus.round_num    = rnd_q;
    bus.last         = (state_q == StRun) && (rnd_q == 5'd1);
  end

endmodule

// File: tb/tb_des_key_sched_dec.sv
// Scoreboard bench for des_key_sched_dec: stimulus pushes expected subkeys, a forked
// monitor pops and compares on every accepted handshake and checks stall stability.
module tb_des_key_sched_dec;

  typedef struct packed {
    logic [47:0] sk;
    logic [4:0]  rnd;
  } exp_t;

  localparam int unsigned PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int unsigned PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam logic [63:0] STD_KEY = 64'h133457799BBCDFF1;
  localparam logic [47:0] K16_STD = 48'b110010110011110110001011000011100001011111110101;
  localparam logic [47:0] K1_STD  = 48'b000110110000001011101111111111000111000001110010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  des_key_sched_dec_if bus ();

  des_key_sched_dec dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q[$];
  logic [47:0] mk [1:16];

  function automatic logic [63:0] rev64(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = x[63-i];
    return r;
  endfunction

  function automatic logic [47:0] rev48(input logic [47:0] x);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[i] = x[47-i];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s timed out at %0t", name, $time);
  endtask

  // Encryption-order reference schedule; literals hold FIPS bit 1 in the MSB.
  task automatic ref_sched(input logic [63:0] k);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] ks;
    for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 1; r <= 16; r++) begin
      int sh;
      sh = (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
      for (int s = 0; s < sh; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) ks[47-i] = cd[56-PC2[i]];
      mk[r] = ks;
    end
  endtask

  task automatic push_exp(input logic [47:0] sk, input int r);
    exp_t e;
    e.sk  = sk;
    e.rnd = 5'(r);
    q.push_back(e);
  endtask

  task automatic push_model();
    for (int r = 16; r >= 1; r--) push_exp(mk[r], r);
  endtask

  task automatic push_const(input logic [47:0] sk);
    for (int r = 16; r >= 1; r--) push_exp(sk, r);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called in IDLE at posedge+1; returns one edge after the load with K16 presented.
  task automatic load_key(input logic [63:0] k);
    bus.key_in   = rev64(k);
    bus.key_load = 1'b1;
    cyc();
    bus.key_load = 1'b0;
  endtask

  task automatic run_to_idle(output int n);
    int i;
    n = 1;
    for (i = 0; i < 400; i++) begin
      cyc();
      if (!bus.subkey_valid) break;
      n++;
    end
    if (i == 400) timeout("run_to_idle");
  endtask

  task automatic monitor();
    logic        stalled = 1'b0;
    logic [47:0] p_sk;
    logic [4:0]  p_rn;
    logic        p_last;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        check("busy_eq_valid", 64'(bus.busy), 64'(bus.subkey_valid));
        if (stalled && bus.subkey_valid) begin
          check("stall_subkey", 64'(bus.subkey), 64'(p_sk));
          check("stall_round", 64'(bus.round_num), 64'(p_rn));
          check("stall_last", 64'(bus.last), 64'(p_last));
        end
        if (bus.subkey_valid && bus.subkey_ready) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_subkey round=%0d at %0t", bus.round_num, $time);
          end else begin
            e = q.pop_front();
            check("subkey", 64'(rev48(bus.subkey)), 64'(e.sk));
            check("round_num", 64'(bus.round_num), 64'(e.rnd));
            check("last", 64'(bus.last), 64'(e.rnd == 5'd1));
          end
        end
        stalled = bus.subkey_valid && !bus.subkey_ready;
        p_sk    = bus.subkey;
        p_rn    = bus.round_num;
        p_last  = bus.last;
      end
    end
  endtask

  initial begin
    int n;
    logic [63:0] k;
    fork
      monitor();
    join_none

    bus.key_in       = '0;
    bus.key_load     = 1'b0;
    bus.subkey_ready = 1'b1;

    // Reset values
    #3;
    check("rst_valid", 64'(bus.subkey_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_last", 64'(bus.last), 64'd0);
    check("rst_subkey", 64'(bus.subkey), 64'd0);
    check("rst_round", 64'(bus.round_num), 64'd0);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();

    // Standard vector with hand-computed first and last subkeys
    ref_sched(STD_KEY);
    push_exp(K16_STD, 16);
    for (int r = 15; r >= 2; r--) push_exp(mk[r], r);
    push_exp(K1_STD, 1);
    load_key(STD_KEY);
    run_to_idle(n);
    check("std_valid_cycles", 64'(n), 64'd16);
    check("std_drain", 64'(q.size()), 64'd0);

    // Reset mid-run after five accepts
    push_model();
    load_key(STD_KEY);
    repeat (5) cyc();
    check("pre_rst_round", 64'(bus.round_num), 64'd11);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", 64'(bus.subkey_valid), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_last", 64'(bus.last), 64'd0);
    check("midrst_subkey", 64'(bus.subkey), 64'd0);
    check("midrst_round", 64'(bus.round_num), 64'd0);
    q.delete();
    cyc();
    rst = 1'b0;
    cyc();
    check("post_rst_idle", 64'(bus.subkey_valid), 64'd0);
    push_model();
    load_key(STD_KEY);
    run_to_idle(n);
    check("restart_drain", 64'(q.size()), 64'd0);

    // Weak keys and parity-insensitivity
    push_const(48'h0);
    load_key(64'h0101010101010101);
    run_to_idle(n);
    push_const(48'hFFFF_FFFF_FFFF);
    load_key(64'hFEFEFEFEFEFEFEFE);
    run_to_idle(n);
    push_const(48'h0);
    load_key(64'h0000000000000000);
    run_to_idle(n);
    check("weak_drain", 64'(q.size()), 64'd0);

    // Random cross-check; after K1 the halves sit at C1/D1
    for (int t = 0; t < 20; t++) begin
      k = {$urandom, $urandom};
      ref_sched(k);
      push_model();
      load_key(k);
      run_to_idle(n);
      check("cd_after_k1", 64'(rev48(bus.subkey)), 64'(mk[1]));
    end
    check("rand_drain", 64'(q.size()), 64'd0);

    // Backpressure with 10-cycle stalls on rounds 16, 9 and 1
    begin
      int s16, s9, s1, i;
      s16 = 0; s9 = 0; s1 = 0;
      k = 64'h0E329232EA6D0D73;
      ref_sched(k);
      push_model();
      load_key(k);
      for (i = 0; i < 600; i++) begin
        if (bus.round_num == 5'd16 && s16 < 10) begin
          bus.subkey_ready = 1'b0; s16++;
        end else if (bus.round_num == 5'd9 && s9 < 10) begin
          bus.subkey_ready = 1'b0; s9++;
        end else if (bus.round_num == 5'd1 && s1 < 10) begin
          bus.subkey_ready = 1'b0; s1++;
        end else begin
          bus.subkey_ready = 1'($urandom_range(0, 1));
        end
        cyc();
        if (!bus.subkey_valid) break;
      end
      if (i == 600) timeout("backpressure");
      bus.subkey_ready = 1'b1;
      check("bp_drain", 64'(q.size()), 64'd0);
    end

    // key_load during RUN is ignored
    ref_sched(STD_KEY);
    push_model();
    load_key(STD_KEY);
    repeat (3) cyc();
    bus.key_in   = rev64(64'hFEDCBA9876543210);
    bus.key_load = 1'b1;
    cyc();
    bus.key_load = 1'b0;
    run_to_idle(n);
    check("ignore_load_drain", 64'(q.size()), 64'd0);
    cyc();
    check("ignore_load_idle", 64'(bus.subkey_valid), 64'd0);

    // key_load held high: back-to-back schedules with one IDLE cycle between
    begin
      int run1, gap, run2, phase, i;
      run1 = 0; gap = 0; run2 = 0; phase = 0;
      k = 64'hA1B2C3D4E5F60718;
      ref_sched(k);
      push_model();
      push_model();
      bus.key_in   = rev64(k);
      bus.key_load = 1'b1;
      for (i = 0; i < 60 && phase < 3; i++) begin
        cyc();
        case (phase)
          0: if (bus.subkey_valid) run1++; else begin phase = 1; gap = 1; end
          1: if (bus.subkey_valid) begin phase = 2; run2 = 1; bus.key_load = 1'b0; end
             else gap++;
          default: if (bus.subkey_valid) run2++; else phase = 3;
        endcase
      end
      bus.key_load = 1'b0;
      if (phase < 3) timeout("held_load");
      check("held_run1", 64'(run1), 64'd16);
      check("held_gap", 64'(gap), 64'd1);
      check("held_run2", 64'(run2), 64'd16);
      check("held_drain", 64'(q.size()), 64'd0);
    end

    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
